rnd_iter_sequencer: RTL

Parametrised successor to the single-width RND control decoder. It owns a self-timed iterated linear-congruential generator, Y(n+1) = (Mult*Y(n) + Incr) mod 2^DATA_W, and runs it for Loop_Value iterations. Each iteration uses a bit-serial shift-add multiply, followed by one add/commit cycle. It includes its own FSM, loop counter, step counter and datapath. It supports two modes: mode 0 returns the final Y; mode 1 returns the running sum of all generated Y values. It connects to the CPU state machine through a Start/Busy/Done handshake, replacing the external RND_State/Exec1/Exec2 sequencing.

---
 rtl/rnd_iter_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rnd_iter_sequencer.sv
// rnd_iter_sequencer: self-timed iterated LCG, Y(n+1) = (Mult*Y(n) + Incr) mod 2^DATA_W.
// Each iteration is DATA_W bit-serial shift-add multiply cycles followed by one
// add/commit cycle. Mode 0 returns the final Y, mode 1 the wrapped sum of all Y.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Start; operands captured on the accept edge
// MUL   | one multiplier bit per cycle, LSB first, DATA_W cycles
// ADD   | Ynew = product + Incr, accumulate Sum, reload for next pass
// DONE  | one-cycle Done pulse, Result already registered on entry
module rnd_iter_sequencer #(
    parameter int DATA_W = 16,
    parameter int LOOP_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Mode,
    input  logic [LOOP_W-1:0] Loop_Value,
    input  logic [DATA_W-1:0] Seed,
    input  logic [DATA_W-1:0] Mult,
    input  logic [DATA_W-1:0] Incr,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Result,
    output logic [LOOP_W-1:0] Iter_Done
);

    // Step counter must reach DATA_W-1; the +1 keeps it non-zero width for DATA_W=1.
    localparam int STEP_W = $clog2(DATA_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DATA_W - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [LOOP_W-1:0] LOOP_ONE  = LOOP_W'(1);
    localparam logic [LOOP_W-1:0] LOOP_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] product;
    logic [DATA_W-1:0] mcand_sr;
    logic [DATA_W-1:0] mplier_sr;
    logic [DATA_W-1:0] mult_cap;
    logic [DATA_W-1:0] incr_cap;
    logic              mode_cap;
    logic [LOOP_W-1:0] remaining;
    logic [LOOP_W-1:0] iter_cnt;
    logic [STEP_W-1:0] step;
    logic [DATA_W-1:0] result_q;

    logic              mul_last;
    logic              last_iter;
    logic [DATA_W-1:0] y_new;
    logic [DATA_W-1:0] sum_new;
    logic [DATA_W-1:0] partial;

    assign mul_last  = (step == STEP_LAST);
    assign last_iter = (remaining == LOOP_ONE);
    assign y_new     = product + incr_cap;
    assign sum_new   = sum + y_new;
    assign partial   = mplier_sr[0] ? mcand_sr : '0;

    assign Busy      = (state == S_MUL) || (state == S_ADD);
    assign Done      = (state == S_DONE);
    assign Result    = result_q;
    assign Iter_Done = iter_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; Abort only matters while the run is busy, Start only in IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = (Loop_Value != LOOP_ZERO) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (Abort) begin
                    state_next = S_IDLE;
                end else if (mul_last) begin
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                if (Abort) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = last_iter ? S_DONE : S_MUL;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add multiply and per-iteration commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            y         <= '0;
            sum       <= '0;
            product   <= '0;
            mcand_sr  <= '0;
            mplier_sr <= '0;
            mult_cap  <= '0;
            incr_cap  <= '0;
            mode_cap  <= 1'b0;
            remaining <= '0;
            iter_cnt  <= '0;
            step      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        y         <= Seed;
                        mcand_sr  <= Seed;
                        mplier_sr <= Mult;
                        mult_cap  <= Mult;
                        incr_cap  <= Incr;
                        mode_cap  <= Mode;
                        remaining <= Loop_Value;
                        sum       <= '0;
                        product   <= '0;
                        iter_cnt  <= '0;
                        step      <= '0;
                    end
                end
                S_MUL: begin
                    if (!Abort) begin
                        product   <= product + partial;
                        mcand_sr  <= mcand_sr << 1;
                        mplier_sr <= mplier_sr >> 1;
                        step      <= step + STEP_ONE;
                    end
                end
                S_ADD: begin
                    // An abort here drops the iteration so Iter_Done stays frozen.
                    if (!Abort) begin
                        y         <= y_new;
                        sum       <= sum_new;
                        remaining <= remaining - LOOP_ONE;
                        iter_cnt  <= iter_cnt + LOOP_ONE;
                        mcand_sr  <= y_new;
                        mplier_sr <= mult_cap;
                        product   <= '0;
                        step      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result is loaded on the edge entering DONE so it is valid alongside the Done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else if (state == S_IDLE && Start && Loop_Value == LOOP_ZERO) begin
            result_q <= Mode ? '0 : Seed;
        end else if (state == S_ADD && !Abort && last_iter) begin
            result_q <= mode_cap ? sum_new : y_new;
        end
    end

endmodule
